// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word-aligned fetches, fills the IF/ID
// register, absorbs decode stalls with a one-entry skid and flushes on redirect.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    instruction_fetch_if.master        imem,
    output logic                       if_id_valid,
    output logic [31:0]                if_id_instr,
    output logic [31:0]                if_id_pc,
    output logic                       misalign_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] kill_addr, kill_addr_next;
    logic [31:0] skid_instr, skid_instr_next;
    logic [31:0] skid_pc, skid_pc_next;
    logic        if_id_valid_next;
    logic [31:0] if_id_instr_next;
    logic [31:0] if_id_pc_next;
    logic        misalign_err_next;
    logic        req;

    // KILL keeps presenting the abandoned address so the memory sees a
    // stable request until its response arrives and is dropped.
    assign req            = (state == FETCH) || (state == KILL);
    assign imem.imem_req  = req;
    assign imem.imem_addr = (state == KILL) ? kill_addr : pc;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_next        = state;
        pc_next           = pc;
        kill_addr_next    = kill_addr;
        skid_instr_next   = skid_instr;
        skid_pc_next      = skid_pc;
        if_id_valid_next  = if_id_valid;
        if_id_instr_next  = if_id_instr;
        if_id_pc_next     = if_id_pc;
        misalign_err_next = 1'b0;

        if (redirect_valid) begin
            pc_next           = {redirect_pc[31:2], 2'b00};
            if_id_valid_next  = 1'b0;
            if_id_instr_next  = NOP_INSTR;
            misalign_err_next = |redirect_pc[1:0];
            if (req && !imem.imem_ready) begin
                state_next = KILL;
                // A redirect already in KILL keeps the original in-flight address.
                if (state == FETCH) begin
                    kill_addr_next = pc;
                end
            end else begin
                state_next = FETCH;
            end
        end else begin
            unique case (state)
                BOOT: begin
                    state_next = FETCH;
                end
                FETCH: begin
                    if (imem.imem_ready) begin
                        pc_next = pc + 32'd4;
                        if (stall) begin
                            skid_instr_next = imem.imem_rdata;
                            skid_pc_next    = pc;
                            state_next      = HOLD;
                        end else begin
                            if_id_valid_next = 1'b1;
                            if_id_instr_next = imem.imem_rdata;
                            if_id_pc_next    = pc;
                        end
                    end else if (!stall) begin
                        if_id_valid_next = 1'b0;
                        if_id_instr_next = NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_valid_next = 1'b1;
                        if_id_instr_next = skid_instr;
                        if_id_pc_next    = skid_pc;
                        state_next       = FETCH;
                    end
                end
                KILL: begin
                    // Stall is irrelevant here: IF/ID already holds a bubble.
                    if (imem.imem_ready) begin
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            kill_addr    <= RESET_PC;
            // NOTE: the skid is only two registers, so it is cleared on reset like the rest of the state.
            skid_instr   <= NOP_INSTR;
            skid_pc      <= 32'h0000_0000;
            if_id_valid  <= 1'b0;
            if_id_instr  <= NOP_INSTR;
            if_id_pc     <= 32'h0000_0000;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            kill_addr    <= kill_addr_next;
            skid_instr   <= skid_instr_next;
            skid_pc      <= skid_pc_next;
            if_id_valid  <= if_id_valid_next;
            if_id_instr  <= if_id_instr_next;
            if_id_pc     <= if_id_pc_next;
            misalign_err <= misalign_err_next;
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013 (ADDI x0,x0,0), instruction driven on bubbles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  decode stage cannot accept; IF/ID register holds.
REQ-006 redirect_valid  input  1  taken branch/jump from downstream; flush and redirect.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  fetch address, word aligned.
REQ-010 imem_ready  input  1  memory response; imem_rdata valid this cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-013 if_id_instr  output  32  instruction to decoder.
REQ-014 if_id_pc  output  32  address of if_id_instr.
REQ-015 misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] nonzero.

Function
REQ-016 States: BOOT, FETCH, HOLD, KILL; encoding free.
REQ-017 BOOT: imem_req=0; unconditionally to FETCH next cycle.
REQ-018 FETCH: imem_req=1, imem_addr=pc; imem_req and imem_addr stay stable until imem_ready unless redirect occurs.
REQ-019 FETCH, imem_ready=1, stall=0: if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0); stay FETCH; back-to-back zero-wait memory yields one instruction per cycle.
REQ-020 FETCH, imem_ready=1, stall=1: IF/ID holds; response into skid register (data, pc); pc<=pc+4; go HOLD.
REQ-021 FETCH, imem_ready=0, stall=0: if_id_valid<=0, if_id_instr<=NOP_INSTR (bubble); if_id_pc holds.
REQ-022 Any state, stall=1, no redirect: IF/ID register unchanged.
REQ-023 HOLD: imem_req=0; when stall=0: IF/ID<=skid, if_id_valid<=1, go FETCH.
REQ-024 Redirect priority over stall, response, HOLD: pc<={redirect_pc[31:2],2'b00}, if_id_valid<=0, if_id_instr<=NOP_INSTR, skid discarded.
REQ-025 Redirect next state: KILL if imem_req=1 and imem_ready=0 that cycle, else FETCH.
REQ-026 Redirect with imem_ready=1 same cycle: response discarded, no IF/ID write, no KILL.
REQ-027 KILL: imem_req=1 with imem_addr = old address; on imem_ready response discarded, go FETCH; IF/ID stays bubble; a further redirect in KILL updates pc only, stays KILL.
REQ-028 misalign_err=1 for the cycle after a redirect with redirect_pc[1:0]!=0; 0 otherwise.
REQ-029 Stall during KILL does not affect KILL exit; after exit, stall rules apply.
REQ-030 if_id_valid=1 only for instructions fetched at the current redirected path.

Reset
REQ-031 rst=1 overrides all inputs; next cycle: state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, skid empty, misalign_err=0.
REQ-032 Reset mid-request (FETCH or KILL): outstanding response ignored; first post-reset request to RESET_PC issued in FETCH after BOOT.

Verification
REQ-033 Reset release, imem_ready tied 1, rdata=addr: if_id_pc 0,4,8,... consecutive cycles, if_id_valid=1 from 3rd cycle after reset release.
REQ-034 imem_ready low 3 cycles at addr 8: imem_addr stable at 8, three bubbles with if_id_instr=32'h13, then instr at pc 8.
REQ-035 stall=1 with response at addr 0xC: IF/ID holds prior instr, imem_req=0 in HOLD; stall release -> if_id_pc=0xC next cycle, then fetch 0x10.
REQ-036 redirect_pc=0x100 while request to 0x20 outstanding (ready=0): KILL, 0x20 response discarded, next valid if_id_pc=0x100.
REQ-037 redirect_pc=0x102 with stall=1: if_id_valid=0 next cycle, misalign_err pulse 1 cycle, fetch at 0x100.
REQ-038 pc=0xFFFF_FFFC fetch: next imem_addr=0x0000_0000; rst asserted mid-KILL -> BOOT, fetch restarts at RESET_PC.
